tube_bus_arbiter: RTL and testbench

Shares the 8-bit Tube parasite bus between two requesters: the CPC Z80 host I/O path and an auxiliary PMOD-side requester. Arbitrates between them, then sequences one complete Tube bus cycle (CS, RnW, address, PHI1/PHI2 phases, data drive/capture) with programmable phase lengths. Uses a req/ack handshake on each side. Sits between the host port decode logic and the Tube connector pins.

---
 rtl/tube_ctrl_pkg.sv | 19 +
 rtl/tube_rr_arb.sv | 62 ++++++
 rtl/tube_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_tube_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_ctrl_pkg.sv
// Shared definitions for the Tube bus controller slice.
// Holds the bus-cycle state encoding, the requester index constants used to
// address GRANT/REQ vectors, and the Tube register address width.
package tube_ctrl_pkg;

    localparam int unsigned TUBE_ADR_W = 3;

    // Bit positions in the two-requester REQ/GRANT vectors.
    localparam int unsigned REQ_HOST = 0;
    localparam int unsigned REQ_AUX  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } tube_state_e;

endpackage

// File: rtl/tube_rr_arb.sv
// Two-way arbiter for the Tube bus.
// Optional feature macro: TUBE_RR_ARB_EN
//   defined   - round-robin: on a tie the requester not granted last wins;
//               after reset the host wins the first tie.
//   undefined - fixed priority, host always wins a tie (no pointer state).
// Ports:
//   CLK     system clock
//   RESET   synchronous, active-high reset (clears the round-robin pointer)
//   REQ     request vector, [0]=host, [1]=aux
//   UPDATE  strobe: the current GRANT is being accepted, advance the pointer
//   GRANT   combinational one-hot grant (00 when no request)
module tube_rr_arb
    import tube_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic       UPDATE,
    output logic [1:0] GRANT
);

`ifdef TUBE_RR_ARB_EN
    // Set when aux was the last requester granted. Resetting it to 1 makes
    // the host the preferred winner of the first tie.
    logic last_aux_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_aux_q <= 1'b1;
        end else if (UPDATE && (|GRANT)) begin
            last_aux_q <= GRANT[REQ_AUX];
        end
    end

    always_comb begin
        GRANT = 2'b00;
        if (REQ[REQ_HOST] && REQ[REQ_AUX]) begin
            if (last_aux_q) begin
                GRANT[REQ_HOST] = 1'b1;
            end else begin
                GRANT[REQ_AUX] = 1'b1;
            end
        end else begin
            GRANT = REQ;
        end
    end
`else
    // No pointer in fixed-priority mode; clock, reset and strobe are idle.
    logic unused_inputs;
    assign unused_inputs = ^{CLK, RESET, UPDATE};

    always_comb begin
        GRANT = 2'b00;
        if (REQ[REQ_HOST]) begin
            GRANT[REQ_HOST] = 1'b1;
        end else if (REQ[REQ_AUX]) begin
            GRANT[REQ_AUX] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/tube_bus_arbiter.sv
// Tube parasite bus arbiter and cycle sequencer.
// Arbitrates between the CPC host I/O path and an auxiliary requester, then
// runs one full Tube bus cycle: SETUP (CS low, PHI2 low) -> STROBE (PHI2 high)
// -> HOLD (one cycle, PHI2 low, CS/OE held, ACK pulse) -> IDLE.
// Optional feature macro: TUBE_RR_ARB_EN (round-robin tie-break, see
// tube_rr_arb); undefined gives fixed host priority.
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   HOST_REQ/RNW/ADR/WDATA, HOST_ACK host requester handshake
//   AUX_REQ/RNW/ADR/WDATA, AUX_ACK   aux requester handshake
//   RDATA                            captured read data (both requesters)
//   GRANT                            one-hot owner, [0]=host, [1]=aux
//   BUSY                             high outside IDLE
//   TUBE_ADR/RNW_B/CS_B/PHI2         Tube bus control pins
//   TUBE_DATA_OUT/OE, TUBE_DATA_IN   Tube data pin driver and receiver
// Every output is a flop so PHI2 and CS_B are glitch-free.
module tube_bus_arbiter
    import tube_ctrl_pkg::*;
#(
    parameter int unsigned PHI1_CYCLES = 1,
    parameter int unsigned PHI2_CYCLES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HOST_REQ,
    input  logic                  HOST_RNW,
    input  logic [TUBE_ADR_W-1:0] HOST_ADR,
    input  logic [7:0]            HOST_WDATA,
    output logic                  HOST_ACK,
    input  logic                  AUX_REQ,
    input  logic                  AUX_RNW,
    input  logic [TUBE_ADR_W-1:0] AUX_ADR,
    input  logic [7:0]            AUX_WDATA,
    output logic                  AUX_ACK,
    output logic [7:0]            RDATA,
    output logic [1:0]            GRANT,
    output logic                  BUSY,
    output logic [TUBE_ADR_W-1:0] TUBE_ADR,
    output logic                  TUBE_RNW_B,
    output logic                  TUBE_CS_B,
    output logic                  TUBE_PHI2,
    output logic [7:0]            TUBE_DATA_OUT,
    output logic                  TUBE_DATA_OE,
    input  logic [7:0]            TUBE_DATA_IN
);

    localparam logic [CNT_W-1:0] PHI1_LOAD = CNT_W'(PHI1_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHI2_LOAD = CNT_W'(PHI2_CYCLES - 1);

    tube_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cs_b_q, cs_b_d;
    logic                  phi2_q, phi2_d;
    logic                  rnw_b_q, rnw_b_d;
    logic                  oe_q, oe_d;
    logic [TUBE_ADR_W-1:0] adr_q, adr_d;
    logic [7:0]            dout_q, dout_d;
    logic [7:0]            rdata_q, rdata_d;
    logic [1:0]            grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  host_ack_q, host_ack_d;
    logic                  aux_ack_q, aux_ack_d;

    logic [1:0]            arb_grant;
    logic                  arb_update;
    logic                  win_aux;

    tube_rr_arb u_arb (
        .CLK    (CLK),
        .RESET  (RESET),
        .REQ    ({AUX_REQ, HOST_REQ}),
        .UPDATE (arb_update),
        .GRANT  (arb_grant)
    );

    assign win_aux = arb_grant[REQ_AUX];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_b_d     = cs_b_q;
        phi2_d     = phi2_q;
        rnw_b_d    = rnw_b_q;
        oe_d       = oe_q;
        adr_d      = adr_q;
        dout_d     = dout_q;
        rdata_d    = rdata_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        host_ack_d = 1'b0;
        aux_ack_d  = 1'b0;
        arb_update = 1'b0;

        case (state_q)
            StIdle: begin
                // Requests are only looked at here, so a running cycle is
                // never pre-empted.
                if (|arb_grant) begin
                    arb_update = 1'b1;
                    grant_d    = arb_grant;
                    rnw_b_d    = win_aux ? AUX_RNW : HOST_RNW;
                    adr_d      = win_aux ? AUX_ADR : HOST_ADR;
                    dout_d     = win_aux ? AUX_WDATA : HOST_WDATA;
                    oe_d       = ~(win_aux ? AUX_RNW : HOST_RNW);
                    cs_b_d     = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = PHI1_LOAD;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    phi2_d  = 1'b1;
                    cnt_d   = PHI2_LOAD;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    // Capture on the same edge that drops PHI2.
                    phi2_d = 1'b0;
                    if (rnw_b_q) begin
                        rdata_d = TUBE_DATA_IN;
                    end
                    host_ack_d = grant_q[REQ_HOST];
                    aux_ack_d  = grant_q[REQ_AUX];
                    state_d    = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                cs_b_d  = 1'b1;
                oe_d    = 1'b0;
                rnw_b_d = 1'b1;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cs_b_q     <= 1'b1;
            phi2_q     <= 1'b0;
            rnw_b_q    <= 1'b1;
            oe_q       <= 1'b0;
            adr_q      <= '0;
            dout_q     <= '0;
            rdata_q    <= '0;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            host_ack_q <= 1'b0;
            aux_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_b_q     <= cs_b_d;
            phi2_q     <= phi2_d;
            rnw_b_q    <= rnw_b_d;
            oe_q       <= oe_d;
            adr_q      <= adr_d;
            dout_q     <= dout_d;
            rdata_q    <= rdata_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            host_ack_q <= host_ack_d;
            aux_ack_q  <= aux_ack_d;
        end
    end

    assign TUBE_ADR      = adr_q;
    assign TUBE_RNW_B    = rnw_b_q;
    assign TUBE_CS_B     = cs_b_q;
    assign TUBE_PHI2     = phi2_q;
    assign TUBE_DATA_OUT = dout_q;
    assign TUBE_DATA_OE  = oe_q;
    assign RDATA         = rdata_q;
    assign GRANT         = grant_q;
    assign BUSY          = busy_q;
    assign HOST_ACK      = host_ack_q;
    assign AUX_ACK       = aux_ack_q;

endmodule

// File: tb/tb_tube_bus_arbiter.sv
// Directed testbench for tube_bus_arbiter. A second instance with
// PHI1_CYCLES=2, PHI2_CYCLES=3 covers non-default phase lengths.
module tb_tube_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       HOST_REQ, HOST_RNW;
    logic [2:0] HOST_ADR;
    logic [7:0] HOST_WDATA;
    logic       AUX_REQ, AUX_RNW;
    logic [2:0] AUX_ADR;
    logic [7:0] AUX_WDATA;
    logic [7:0] TUBE_DATA_IN;
    logic       H2_REQ;

    logic       HOST_ACK, AUX_ACK, BUSY, TUBE_RNW_B, TUBE_CS_B, TUBE_PHI2, TUBE_DATA_OE;
    logic [7:0] RDATA, TUBE_DATA_OUT;
    logic [1:0] GRANT;
    logic [2:0] TUBE_ADR;

    logic       d2_host_ack, d2_aux_ack, d2_busy, d2_rnw_b, d2_cs_b, d2_phi2, d2_oe;
    logic [7:0] d2_rdata, d2_dout;
    logic [1:0] d2_grant;
    logic [2:0] d2_adr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    tube_bus_arbiter dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .HOST_REQ      (HOST_REQ),
        .HOST_RNW      (HOST_RNW),
        .HOST_ADR      (HOST_ADR),
        .HOST_WDATA    (HOST_WDATA),
        .HOST_ACK      (HOST_ACK),
        .AUX_REQ       (AUX_REQ),
        .AUX_RNW       (AUX_RNW),
        .AUX_ADR       (AUX_ADR),
        .AUX_WDATA     (AUX_WDATA),
        .AUX_ACK       (AUX_ACK),
        .RDATA         (RDATA),
        .GRANT         (GRANT),
        .BUSY          (BUSY),
        .TUBE_ADR      (TUBE_ADR),
        .TUBE_RNW_B    (TUBE_RNW_B),
        .TUBE_CS_B     (TUBE_CS_B),
        .TUBE_PHI2     (TUBE_PHI2),
        .TUBE_DATA_OUT (TUBE_DATA_OUT),
        .TUBE_DATA_OE  (TUBE_DATA_OE),
        .TUBE_DATA_IN  (TUBE_DATA_IN)
    );

    tube_bus_arbiter #(
        .PHI1_CYCLES (2),
        .PHI2_CYCLES (3),
        .CNT_W       (4)
    ) dut2 (
        .CLK           (CLK),
        .RESET         (RESET),
        .HOST_REQ      (H2_REQ),
        .HOST_RNW      (HOST_RNW),
        .HOST_ADR      (HOST_ADR),
        .HOST_WDATA    (HOST_WDATA),
        .HOST_ACK      (d2_host_ack),
        .AUX_REQ       (1'b0),
        .AUX_RNW       (1'b0),
        .AUX_ADR       (3'd0),
        .AUX_WDATA     (8'd0),
        .AUX_ACK       (d2_aux_ack),
        .RDATA         (d2_rdata),
        .GRANT         (d2_grant),
        .BUSY          (d2_busy),
        .TUBE_ADR      (d2_adr),
        .TUBE_RNW_B    (d2_rnw_b),
        .TUBE_CS_B     (d2_cs_b),
        .TUBE_PHI2     (d2_phi2),
        .TUBE_DATA_OUT (d2_dout),
        .TUBE_DATA_OE  (d2_oe),
        .TUBE_DATA_IN  (TUBE_DATA_IN)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [1:0] exp_owner;

        RESET        = 1'b1;
        HOST_REQ     = 1'b0;
        HOST_RNW     = 1'b1;
        HOST_ADR     = 3'd0;
        HOST_WDATA   = 8'h00;
        AUX_REQ      = 1'b0;
        AUX_RNW      = 1'b1;
        AUX_ADR      = 3'd0;
        AUX_WDATA    = 8'h00;
        TUBE_DATA_IN = 8'h00;
        H2_REQ       = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst cs_b", TUBE_CS_B, 1);
        check_eq("rst phi2", TUBE_PHI2, 0);
        check_eq("rst rnw_b", TUBE_RNW_B, 1);
        check_eq("rst oe", TUBE_DATA_OE, 0);
        check_eq("rst adr", TUBE_ADR, 0);
        check_eq("rst dout", TUBE_DATA_OUT, 0);
        check_eq("rst acks", {HOST_ACK, AUX_ACK}, 0);
        check_eq("rst grant", GRANT, 0);
        check_eq("rst busy", BUSY, 0);
        check_eq("rst rdata", RDATA, 0);
        RESET = 1'b0;
        tick();

        // 1: host write ADR=3 A5, default phases
        HOST_RNW = 1'b0; HOST_ADR = 3'd3; HOST_WDATA = 8'hA5; HOST_REQ = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_eq($sformatf("t1 cs_b c%0d", c), TUBE_CS_B, (c <= 4) ? 0 : 1);
            check_eq($sformatf("t1 phi2 c%0d", c), TUBE_PHI2, (c == 2 || c == 3));
            check_eq($sformatf("t1 host_ack c%0d", c), HOST_ACK, (c == 4));
            check_eq($sformatf("t1 aux_ack c%0d", c), AUX_ACK, 0);
            check_eq($sformatf("t1 busy c%0d", c), BUSY, (c <= 4));
            if (c <= 4) begin
                check_eq($sformatf("t1 adr c%0d", c), TUBE_ADR, 3);
                check_eq($sformatf("t1 rnw_b c%0d", c), TUBE_RNW_B, 0);
                check_eq($sformatf("t1 oe c%0d", c), TUBE_DATA_OE, 1);
                check_eq($sformatf("t1 dout c%0d", c), TUBE_DATA_OUT, 8'hA5);
                check_eq($sformatf("t1 grant c%0d", c), GRANT, 2'b01);
            end else begin
                check_eq("t1 oe idle", TUBE_DATA_OE, 0);
                check_eq("t1 rnw_b idle", TUBE_RNW_B, 1);
                check_eq("t1 grant idle", GRANT, 0);
            end
            if (c == 4) HOST_REQ = 1'b0;
        end

        // 2: aux read ADR=5, pins show 3C only during STROBE
        AUX_RNW = 1'b1; AUX_ADR = 3'd5; AUX_WDATA = 8'hFF; AUX_REQ = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) TUBE_DATA_IN = 8'h3C;
            if (c == 4) TUBE_DATA_IN = 8'h77;
            check_eq($sformatf("t2 grant c%0d", c), GRANT, (c <= 4) ? 2'b10 : 2'b00);
            check_eq($sformatf("t2 rnw_b c%0d", c), TUBE_RNW_B, 1);
            check_eq($sformatf("t2 oe c%0d", c), TUBE_DATA_OE, 0);
            check_eq($sformatf("t2 aux_ack c%0d", c), AUX_ACK, (c == 4));
            check_eq($sformatf("t2 host_ack c%0d", c), HOST_ACK, 0);
            if (c <= 4) check_eq($sformatf("t2 adr c%0d", c), TUBE_ADR, 5);
            if (c >= 4) check_eq($sformatf("t2 rdata c%0d", c), RDATA, 8'h3C);
            if (c == 4) AUX_REQ = 1'b0;
        end

        // 3: both requesting continuously; last grant was aux
        HOST_RNW = 1'b0; HOST_ADR = 3'd1; HOST_WDATA = 8'h11;
        AUX_RNW  = 1'b0; AUX_ADR  = 3'd2; AUX_WDATA  = 8'h22;
        HOST_REQ = 1'b1; AUX_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef TUBE_RR_ARB_EN
            exp_owner = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_owner = 2'b01;
`endif
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (c == 1) begin
                    check_eq($sformatf("t3 grant k%0d", k), GRANT, exp_owner);
                    check_eq($sformatf("t3 adr k%0d", k), TUBE_ADR, exp_owner[1] ? 2 : 1);
                    check_eq($sformatf("t3 cs_b k%0d", k), TUBE_CS_B, 0);
                end
                if (c == 4) begin
                    check_eq($sformatf("t3 host_ack k%0d", k), HOST_ACK, exp_owner[0]);
                    check_eq($sformatf("t3 aux_ack k%0d", k), AUX_ACK, exp_owner[1]);
                    if (k == 3) begin
                        HOST_REQ = 1'b0;
                        AUX_REQ  = 1'b0;
                    end
                end
                if (c == 5) begin
                    check_eq($sformatf("t3 busy gap k%0d", k), BUSY, 0);
                    check_eq($sformatf("t3 cs_b gap k%0d", k), TUBE_CS_B, 1);
                end
            end
        end

        // 4: PHI1=2, PHI2=3 instance
        HOST_RNW = 1'b0; HOST_ADR = 3'd4; HOST_WDATA = 8'h5A; H2_REQ = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_eq($sformatf("t4 cs_b c%0d", c), d2_cs_b, (c <= 6) ? 0 : 1);
            check_eq($sformatf("t4 phi2 c%0d", c), d2_phi2, (c >= 3 && c <= 5));
            check_eq($sformatf("t4 ack c%0d", c), d2_host_ack, (c == 6));
            if (c == 6) H2_REQ = 1'b0;
        end
        check_eq("t4 main idle", BUSY, 0);

        // 5: reset in the second STROBE cycle
        HOST_RNW = 1'b0; HOST_ADR = 3'd6; HOST_WDATA = 8'hC3; HOST_REQ = 1'b1;
        for (int c = 1; c <= 3; c++) tick();
        check_eq("t5 phi2 pre", TUBE_PHI2, 1);
        check_eq("t5 rdata pre", RDATA, 8'h3C);
        RESET = 1'b1;
        tick();
        check_eq("t5 cs_b", TUBE_CS_B, 1);
        check_eq("t5 phi2", TUBE_PHI2, 0);
        check_eq("t5 busy", BUSY, 0);
        check_eq("t5 ack", HOST_ACK, 0);
        check_eq("t5 oe", TUBE_DATA_OE, 0);
        check_eq("t5 grant", GRANT, 0);
        check_eq("t5 rdata", RDATA, 0);
        RESET = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_eq($sformatf("t5b cs_b c%0d", c), TUBE_CS_B, (c <= 4) ? 0 : 1);
            check_eq($sformatf("t5b ack c%0d", c), HOST_ACK, (c == 4));
            if (c <= 4) check_eq($sformatf("t5b dout c%0d", c), TUBE_DATA_OUT, 8'hC3);
            if (c == 4) HOST_REQ = 1'b0;
        end

        // 6: host drops REQ during SETUP; aux queued behind it
        HOST_RNW = 1'b0; HOST_ADR = 3'd7; HOST_WDATA = 8'h96; HOST_REQ = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) HOST_REQ = 1'b0;
            if (c == 2) begin
                AUX_RNW = 1'b1; AUX_ADR = 3'd2; AUX_REQ = 1'b1;
            end
            if (c == 1) check_eq("t6 host grant", GRANT, 2'b01);
            if (c == 4) begin
                check_eq("t6 host_ack", HOST_ACK, 1);
                check_eq("t6 aux_ack early", AUX_ACK, 0);
            end
            if (c == 5) check_eq("t6 idle grant", GRANT, 0);
            if (c == 6) begin
                check_eq("t6 aux grant", GRANT, 2'b10);
                check_eq("t6 aux adr", TUBE_ADR, 2);
            end
            if (c == 9) begin
                check_eq("t6 aux_ack", AUX_ACK, 1);
                check_eq("t6 host_ack none", HOST_ACK, 0);
                AUX_REQ = 1'b0;
            end
        end
        tick();
        check_eq("t6 final busy", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
